// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: operation codes and FSM states.
package alu_pkg;

  typedef enum logic [1:0] {
    FUNC_ADD = 2'b00,
    FUNC_SUB = 2'b01,
    FUNC_MUL = 2'b10,
    FUNC_DIV = 2'b11
  } func_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_iter_core.sv
// Iterative engine shared by multiply and divide: one 2*WIDTH-bit
// accumulator/shift register, one operand register and a step counter.
// Multiply: p = {upper accumulator, multiplier}, m = multiplicand.
// Divide:   p = {remainder, dividend/quotient},  m = divisor.
// After load the core runs exactly WIDTH steps, then raises last and holds.
module alu_iter_core #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               mode,    // 0 = multiply, 1 = divide
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] p;
  logic [2*WIDTH-1:0] p_next;
  logic [WIDTH-1:0]   m;
  logic               mode_q;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;

  // One iteration step: shift-add for multiply, restoring subtract for divide.
  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    mul_sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
    div_shift = p[2*WIDTH-1:WIDTH-1];
    div_trial = div_shift - {1'b0, m};
    p_next    = {mul_sum, p[WIDTH-1:1]};
    if (mode_q) begin
      // A borrow out of the trial subtract means the divisor did not fit:
      // keep the shifted remainder and shift in a 0 quotient bit.
      if (div_trial[WIDTH]) p_next = {div_shift[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
      else                  p_next = {div_trial[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
    end
  end

  assign last   = (cnt == CW'(WIDTH));
  assign result = p;

  // Load operands on request, otherwise step until WIDTH iterations are done.
  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p      <= '0;
      m      <= '0;
      mode_q <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      p      <= mode ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
      m      <= mode ? b : a;
      mode_q <= mode;
      cnt    <= '0;
    end else if (!last) begin
      p      <= p_next;
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle unsigned ALU with start/done handshake. Add/sub and
// divide-by-zero resolve in one CALC cycle; mul/div wait for the iterative
// core. out/ovf only change in DONE and hold until the next result.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         func,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out,
  output logic               ovf
);

  state_e             state;
  state_e             state_next;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  func_e              func_q;
  logic               accept;
  logic               iter_wait;
  logic               core_last;
  logic [2*WIDTH-1:0] core_result;
  logic [WIDTH:0]     add_res;
  logic [WIDTH:0]     sub_res;
  logic [2*WIDTH-1:0] res_next;
  logic               ovf_next;

  assign accept    = (state == ST_IDLE) && start;
  assign busy      = (state != ST_IDLE);
  // Multiply always iterates; divide iterates unless the divisor is zero.
  assign iter_wait = (func_q == FUNC_MUL) || ((func_q == FUNC_DIV) && (b_q != '0));

  // The core loads straight from the ports on the accept edge, so its first
  // step lands on the first CALC edge.
  alu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .mode   (func_e'(func) == FUNC_DIV),
    .a      (a),
    .b      (b),
    .last   (core_last),
    .result (core_result)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic: IDLE -> CALC -> DONE -> IDLE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_CALC;
      ST_CALC: if (!iter_wait || core_last) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand latches: captured only on accept, so later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      func_q <= FUNC_ADD;
    end else if (accept) begin
      a_q    <= a;
      b_q    <= b;
      func_q <= func_e'(func);
    end
  end

  // Result selection per operation, including flag derivation.
  always_comb begin
    add_res  = {1'b0, a_q} + {1'b0, b_q};
    sub_res  = {1'b0, a_q} - {1'b0, b_q};
    res_next = '0;
    ovf_next = 1'b0;
    case (func_q)
      FUNC_ADD: begin
        res_next = {{(WIDTH-1){1'b0}}, add_res};
        ovf_next = add_res[WIDTH];
      end
      FUNC_SUB: begin
        res_next = {{WIDTH{1'b0}}, sub_res[WIDTH-1:0]};
        ovf_next = sub_res[WIDTH];
      end
      FUNC_MUL: begin
        res_next = core_result;
        ovf_next = |core_result[2*WIDTH-1:WIDTH];
      end
      FUNC_DIV: begin
        if (b_q == '0) begin
          res_next = {a_q, {WIDTH{1'b1}}};
          ovf_next = 1'b1;
        end else begin
          res_next = core_result;
        end
      end
      default: ;
    endcase
  end

  // Output registers: update and pulse done only while in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out  <= '0;
      ovf  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= (state == ST_DONE);
      if (state == ST_DONE) begin
        out <= res_next;
        ovf <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: the driver pushes model results, the
// monitor pops and compares on every done pulse.
module tb_alu_seq;

  localparam int W = 6;
  localparam int M = 1 << W;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a     = '0;
  logic [W-1:0]   b     = '0;
  logic [1:0]     func  = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] out;
  logic           ovf;

  typedef struct {
    int res;
    int ovf;
    int done_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   hold_out = 0;
  int   hold_ovf = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .func  (func),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Edge counter: value seen at a negedge equals the number of rising edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the operation definitions.
  function automatic exp_t model(input int f, input int x, input int y, input int now);
    exp_t e;
    int   lat;
    lat = 2;
    case (f)
      0: begin e.res = x + y;             e.ovf = ((x + y) >= M) ? 1 : 0; end
      1: begin e.res = (x - y + M) % M;   e.ovf = (x < y) ? 1 : 0;        end
      2: begin e.res = x * y;             e.ovf = ((x * y) >= M) ? 1 : 0; lat = W + 2; end
      default: begin
        if (y == 0) begin
          e.res = x * M + (M - 1);
          e.ovf = 1;
        end else begin
          e.res = (x % y) * M + (x / y);
          e.ovf = 0;
          lat   = W + 2;
        end
      end
    endcase
    e.done_cyc = now + 1 + lat;
    return e;
  endfunction

  // Monitor: compare every done against the scoreboard; outputs must hold while busy.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_out = 0;
      hold_ovf = 0;
    end else if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("out", int'(out), mon_e.res);
        check("ovf", int'(ovf), mon_e.ovf);
        check("latency", cyc, mon_e.done_cyc);
        check("busy_at_done", int'(busy), 0);
        hold_out = mon_e.res;
        hold_ovf = mon_e.ovf;
      end
    end else if (busy) begin
      check("hold_out", int'(out), hold_out);
      check("hold_ovf", int'(ovf), hold_ovf);
    end
  end

  // Present a request at a negedge; scramble inputs right after acceptance.
  task automatic issue(input int f, input int x, input int y);
    start = 1'b1;
    func  = 2'(f);
    a     = W'(x);
    b     = W'(y);
    sb.push_back(model(f, x, y, cyc));
    @(posedge clk);
    #1;
    check("busy_after_accept", int'(busy), 1);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    func  = 2'($urandom);
  endtask

  // Wait (bounded) until the negedge where done is visible.
  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    check("done_timeout", int'(seen), 1);
  endtask

  task automatic op(input int f, input int x, input int y);
    issue(f, x, y);
    wait_done();
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_out", int'(out), 0);
    check("rst_ovf", int'(ovf), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases, back-to-back
    op(0, 63, 1);
    op(0, 5, 9);
    op(1, 5, 9);
    op(1, 9, 5);
    op(2, 63, 63);
    op(2, 7, 9);
    op(3, 50, 7);
    op(3, 13, 0);
    op(3, 0, 63);
    op(2, 0, 63);

    // Randomized traffic with random idle gaps
    for (int n = 0; n < 80; n++) begin
      int f, x, y;
      f = int'($urandom_range(0, 3));
      x = int'($urandom_range(0, M - 1));
      y = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, M - 1));
      op(f, x, y);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // start held high through an entire multiply: exactly one done expected
    issue(2, 45, 51);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        start = 1'b0;
        break;
      end
      start = busy;
      a     = W'($urandom);
      b     = W'($urandom);
      func  = 2'($urandom);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("storm_sb_empty", sb.size(), 0);

    // Abort a multiply with reset at edge 4
    issue(2, 11, 13);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_out", int'(out), 0);
    check("abort_ovf", int'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    op(3, 50, 7);
    op(0, 5, 9);

    repeat (3) @(negedge clk);
    check("final_sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
